// File: rtl/m_wbuart.sv
// m_wbuart: Wishbone classic UART slave (8N1, LSB first), programmable bit divisor, clamped to >= 4.
// Bus is zero-wait-state (ACK_O = STB_I); TX frame is 10*div cycles; an RX byte is ready ~9.5*div after its start edge.
// DATA writes while TX is busy are dropped; RX pushes into full storage set ovr. Macro WBUART_RXFIFO_EN selects a 4-deep RX FIFO.
module m_wbuart #(
  parameter int DIVWIDTH   = 16,
  parameter int DEFAULTDIV = 104
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic        STB_I,
  input  logic        WE_I,
  input  logic        ADR_I,
  input  logic [3:0]  SEL_I,
  input  logic [31:0] DAT_I,
  output logic [31:0] DAT_O,
  output logic        ACK_O,
  input  logic        usartRX,
  output logic        usartTX,
  output logic        rxirq
);

  localparam logic [DIVWIDTH-1:0] MINDIV = DIVWIDTH'(4);

  typedef enum logic {TX_IDLE, TX_SHIFT} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  // Bus decode
  logic wr_data, wr_ctrl, rd_data;
  assign wr_data = STB_I & WE_I & ~ADR_I & SEL_I[0];
  assign wr_ctrl = STB_I & WE_I & ADR_I;
  assign rd_data = STB_I & ~WE_I & ~ADR_I;
  assign ACK_O   = STB_I;

  // Divisor register and its clamped view used at frame start
  logic [DIVWIDTH-1:0] divisor_q, eff_div;
  assign eff_div = (divisor_q < MINDIV) ? MINDIV : divisor_q;

  // Divisor loads only when both upper byte lanes are selected
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) divisor_q <= DIVWIDTH'(DEFAULTDIV);
    else if (wr_ctrl & SEL_I[3] & SEL_I[2]) divisor_q <= DAT_I[16 +: DIVWIDTH];
  end

  // ---------------- TX ----------------
  tx_state_t           tx_state_q;
  logic [9:0]          tx_sh_q;
  logic [3:0]          tx_bit_q;
  logic [DIVWIDTH-1:0] tx_cnt_q, tx_div_q;
  logic                tx_q;
  logic                txbusy, tx_done, tx_load;

  // tx_done marks the cycle after the stop bit completes; a write there starts the next frame back-to-back
  assign txbusy  = (tx_state_q != TX_IDLE);
  assign tx_done = (tx_state_q == TX_SHIFT) && (tx_bit_q == 4'd10);
  assign tx_load = wr_data & (~txbusy | tx_done);
  assign usartTX = tx_q;

  // TX FSM: the line register follows the shift LSB one cycle behind, so the start bit appears the edge after the write
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      tx_state_q <= TX_IDLE;
      tx_sh_q    <= '1;
      tx_bit_q   <= '0;
      tx_cnt_q   <= '0;
      tx_div_q   <= MINDIV;
      tx_q       <= 1'b1;
    end else begin
      tx_q <= (tx_state_q == TX_SHIFT) ? tx_sh_q[0] : 1'b1;
      if (tx_load) begin
        tx_state_q <= TX_SHIFT;
        tx_sh_q    <= {1'b1, DAT_I[7:0], 1'b0};
        tx_bit_q   <= '0;
        tx_cnt_q   <= '0;
        tx_div_q   <= eff_div;
      end else if (tx_state_q == TX_SHIFT) begin
        if (tx_done) begin
          tx_state_q <= TX_IDLE;
        end else if (tx_cnt_q == tx_div_q - DIVWIDTH'(1)) begin
          tx_cnt_q <= '0;
          tx_sh_q  <= {1'b1, tx_sh_q[9:1]};
          tx_bit_q <= tx_bit_q + 4'd1;
        end else begin
          tx_cnt_q <= tx_cnt_q + DIVWIDTH'(1);
        end
      end
    end
  end

  // ---------------- RX ----------------
  logic rx_s1_q, rx_s2_q, rx_prev_q, rx_fall;
  assign rx_fall = rx_prev_q & ~rx_s2_q;

  // Two-stage synchronizer plus one history stage for falling-edge detection; idles high
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_s1_q   <= usartRX;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
    end
  end

  rx_state_t           rx_state_q;
  logic [DIVWIDTH-1:0] rx_cnt_q, rx_div_q;
  logic [2:0]          rx_bit_q;
  logic [7:0]          rx_sh_q;
  logic                rx_tick, rx_push, rx_ferr_set;

  // Half a bit to the start-bit centre, then a full bit between samples
  assign rx_tick = (rx_state_q == RX_START) ? (rx_cnt_q == (rx_div_q >> 1) - DIVWIDTH'(1))
                                            : (rx_cnt_q == rx_div_q - DIVWIDTH'(1));
  assign rx_push     = (rx_state_q == RX_STOP) & rx_tick & rx_s2_q;
  assign rx_ferr_set = (rx_state_q == RX_STOP) & rx_tick & ~rx_s2_q;

  // RX FSM: start-bit qualify, eight LSB-first data samples, stop check
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_div_q   <= MINDIV;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
    end else begin
      case (rx_state_q)
        RX_IDLE: begin
          if (rx_fall) begin
            rx_state_q <= RX_START;
            rx_cnt_q   <= '0;
            rx_div_q   <= eff_div;
          end
        end
        RX_START: begin
          if (rx_tick) begin
            rx_cnt_q <= '0;
            if (rx_s2_q) begin
              rx_state_q <= RX_IDLE;
            end else begin
              rx_state_q <= RX_DATA;
              rx_bit_q   <= '0;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q + DIVWIDTH'(1);
          end
        end
        RX_DATA: begin
          if (rx_tick) begin
            rx_cnt_q <= '0;
            rx_sh_q  <= {rx_s2_q, rx_sh_q[7:1]};
            rx_bit_q <= rx_bit_q + 3'd1;
            if (rx_bit_q == 3'd7) rx_state_q <= RX_STOP;
          end else begin
            rx_cnt_q <= rx_cnt_q + DIVWIDTH'(1);
          end
        end
        RX_STOP: begin
          if (rx_tick) rx_state_q <= RX_IDLE;
          else         rx_cnt_q   <= rx_cnt_q + DIVWIDTH'(1);
        end
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  // ---------------- RX storage ----------------
  logic       rx_pop, rx_full, rx_push_ok, ovr_set, rxvalid;
  logic [7:0] rx_head;
  logic [2:0] rx_level;

  // A pop in the same cycle frees the slot, so push-with-pop never overruns
  assign rx_pop     = rd_data & rxvalid;
  assign rx_push_ok = rx_push & (~rx_full | rx_pop);
  assign ovr_set    = rx_push & ~rx_push_ok;

`ifdef WBUART_RXFIFO_EN
  logic [7:0] fifo_q [4];
  logic [1:0] wp_q, rp_q;
  logic [2:0] cnt_q, cnt_d;

  assign rx_full  = (cnt_q == 3'd4);
  assign rxvalid  = (cnt_q != 3'd0);
  assign rx_head  = fifo_q[rp_q];
  assign rx_level = cnt_q;

  // Occupancy next-state from the push/pop pair
  always_comb begin
    cnt_d = cnt_q;
    case ({rx_push_ok, rx_pop})
      2'b10:   cnt_d = cnt_q + 3'd1;
      2'b01:   cnt_d = cnt_q - 3'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Circular buffer with wrapping 2-bit pointers
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      for (int i = 0; i < 4; i++) fifo_q[i] <= '0;
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (rx_push_ok) begin
        fifo_q[wp_q] <= rx_sh_q;
        wp_q         <= wp_q + 2'd1;
      end
      if (rx_pop) rp_q <= rp_q + 2'd1;
      cnt_q <= cnt_d;
    end
  end
`else
  logic [7:0] hold_q;
  logic       hold_vld_q;

  assign rx_full  = hold_vld_q;
  assign rxvalid  = hold_vld_q;
  assign rx_head  = hold_q;
  assign rx_level = 3'd0;

  // Single holding register; a push replaces a byte being popped in the same cycle
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
    end else if (rx_push_ok) begin
      hold_q     <= rx_sh_q;
      hold_vld_q <= 1'b1;
    end else if (rx_pop) begin
      hold_vld_q <= 1'b0;
    end
  end
`endif

  assign rxirq = rxvalid;

  // Sticky error flags, write-1-to-clear; a new error in the clear cycle wins
  logic ferr_q, ovr_q;
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      ferr_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      ferr_q <= rx_ferr_set | (ferr_q & ~(wr_ctrl & SEL_I[0] & DAT_I[2]));
      ovr_q  <= ovr_set     | (ovr_q  & ~(wr_ctrl & SEL_I[0] & DAT_I[3]));
    end
  end

  // Read mux; zero when unselected because the top ORs slaves together
  always_comb begin
    DAT_O = 32'd0;
    if (STB_I) begin
      if (ADR_I) DAT_O = {16'(divisor_q), 9'd0, rx_level, ovr_q, ferr_q, rxvalid, txbusy};
      else if (rxvalid) DAT_O = {23'd0, 1'b1, rx_head};
    end
  end

  logic unused_ok;
  assign unused_ok = &{1'b0, SEL_I[1], DAT_I[15:8]};

endmodule

// File: tb/tb_m_wbuart.sv
// tb_m_wbuart: randomized self-checking bench for m_wbuart against a queue-based behavioural model.
// Drives the bus and the serial line cycle by cycle; all checks go through one task.
// Runs a few thousand cycles and ends with a single summary line.
module tb_m_wbuart;

`ifdef WBUART_RXFIFO_EN
  localparam int CAP = 4;
`else
  localparam int CAP = 1;
`endif

  logic        CLK_I = 1'b0, RST_I = 1'b1, STB_I = 1'b0, WE_I = 1'b0, ADR_I = 1'b0;
  logic [3:0]  SEL_I = 4'h0;
  logic [31:0] DAT_I = 32'h0;
  logic [31:0] DAT_O;
  logic        ACK_O, usartRX = 1'b1, usartTX, rxirq;

  m_wbuart dut (
    .CLK_I(CLK_I), .RST_I(RST_I), .STB_I(STB_I), .WE_I(WE_I), .ADR_I(ADR_I),
    .SEL_I(SEL_I), .DAT_I(DAT_I), .DAT_O(DAT_O), .ACK_O(ACK_O),
    .usartRX(usartRX), .usartTX(usartTX), .rxirq(rxirq)
  );

  always #5 CLK_I = ~CLK_I;

  int n_chk = 0, n_pass = 0;

  // Reference model state
  logic [7:0] q[$];
  logic       m_ferr = 1'b0, m_ovr = 1'b0;
  int         m_div = 104;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, want);
  endtask

  function automatic int eff(input int d);
    return (d < 4) ? 4 : d;
  endfunction

  task automatic model_reset();
    q.delete();
    m_ferr = 1'b0;
    m_ovr  = 1'b0;
    m_div  = 104;
  endtask

  task automatic model_push(input logic [7:0] b, input logic stop);
    if (!stop) m_ferr = 1'b1;
    else if (q.size() < CAP) q.push_back(b);
    else m_ovr = 1'b1;
  endtask

  // Bus tasks: entered and left at posedge+1
  task automatic wb_write(input logic adr, input logic [3:0] sel, input logic [31:0] d);
    STB_I = 1'b1; WE_I = 1'b1; ADR_I = adr; SEL_I = sel; DAT_I = d;
    @(posedge CLK_I); #1;
    STB_I = 1'b0; WE_I = 1'b0; SEL_I = 4'h0; DAT_I = 32'h0;
  endtask

  task automatic wb_read(input logic adr, output logic [31:0] d);
    STB_I = 1'b1; WE_I = 1'b0; ADR_I = adr; SEL_I = 4'hF;
    #1;
    d = DAT_O;
    check("ack", ACK_O, 1);
    @(posedge CLK_I); #1;
    STB_I = 1'b0; SEL_I = 4'h0;
  endtask

  task automatic set_div(input int d);
    wb_write(1'b1, 4'b1100, d << 16);
    m_div = d;
  endtask

  task automatic ctrl_chk(input string tag);
    logic [31:0] r, e;
    logic [2:0]  lvl;
    lvl = (CAP == 4) ? 3'(q.size()) : 3'd0;
    e = {16'(m_div), 9'd0, lvl, m_ovr, m_ferr, q.size() > 0, 1'b0};
    wb_read(1'b1, r);
    check(tag, r, e);
  endtask

  task automatic rd_data_chk(input string tag);
    logic [31:0] r, e;
    e = (q.size() > 0) ? {23'd0, 1'b1, q[0]} : 32'd0;
    wb_read(1'b0, r);
    check(tag, r, e);
    if (q.size() > 0) void'(q.pop_front());
  endtask

  task automatic clear_flags(input logic [31:0] v);
    wb_write(1'b1, 4'b0001, v);
    if (v[2]) m_ferr = 1'b0;
    if (v[3]) m_ovr  = 1'b0;
  endtask

  // inj: 0 none, 1 DATA write while busy, 2 divisor change mid-frame
  task automatic tx_frame(input logic [7:0] b, input int inj);
    logic [9:0]  fr;
    logic [31:0] r;
    int d, mism, nd;
    fr = {1'b1, b, 1'b0};
    d = eff(m_div);
    mism = 0;
    wb_write(1'b0, 4'b0001, {24'd0, b});
    for (int t = 1; t <= 10 * d; t++) begin
      if (t == 5 && inj == 1) wb_write(1'b0, 4'b0001, 32'hFF);
      else if (t == 5 && inj == 2) begin
        nd = $urandom_range(0, 12);
        set_div(nd);
      end else begin
        @(posedge CLK_I); #1;
      end
      if (usartTX !== fr[(t - 1) / d]) mism++;
    end
    check("tx_bits", mism, 0);
    wb_read(1'b1, r);
    check("tx_busy_last", r[0], 1);
    wb_read(1'b1, r);
    check("tx_busy_fall", r[0], 0);
    mism = 0;
    for (int i = 0; i < 2 * d; i++) begin
      @(posedge CLK_I); #1;
      if (usartTX !== 1'b1) mism++;
    end
    check("tx_no_extra", mism, 0);
  endtask

  // Drive one serial frame; rxvalid edge timing checked against m+2+(div>>1)+9*div
  task automatic send_frame(input logic [7:0] b, input logic stop, input logic pop_here);
    logic [9:0] fr;
    int d, pc;
    fr = {stop, b, 1'b0};
    d  = eff(m_div);
    pc = 2 + (d >> 1) + 9 * d;
    for (int c = 0; c < 10 * d; c++) begin
      usartRX = fr[c / d];
      if (pop_here && c == pc) rd_data_chk("rx_pop_on_push");
      else begin
        @(posedge CLK_I); #1;
      end
      if (c == pc - 1) check("rx_irq_before", rxirq, q.size() > 0);
      if (c == pc) begin
        model_push(b, stop);
        check("rx_irq_at_push", rxirq, q.size() > 0);
      end
    end
    usartRX = 1'b1;
    repeat (2) begin @(posedge CLK_I); #1; end
  endtask

  task automatic glitch(input int g);
    usartRX = 1'b0;
    repeat (g) begin @(posedge CLK_I); #1; end
    usartRX = 1'b1;
    repeat (eff(m_div) + 4) begin @(posedge CLK_I); #1; end
    check("glitch_irq", rxirq, q.size() > 0);
    check("idle_dat_o", DAT_O, 0);
    check("idle_ack", ACK_O, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] r;
    int op, d;
    model_reset();
    repeat (3) @(posedge CLK_I);
    #1 RST_I = 1'b0;
    check("rst_tx", usartTX, 1);
    check("rst_irq", rxirq, 0);
    check("rst_dat_o", DAT_O, 0);
    check("rst_ack", ACK_O, 0);
    ctrl_chk("rst_ctrl");
    rd_data_chk("rst_data_empty");

    // TX: directed 0x55 at div 8, then write-while-busy, then random frames
    set_div(8);
    tx_frame(8'h55, 0);
    tx_frame(8'hA3, 1);
    for (int i = 0; i < 5; i++) begin
      set_div($urandom_range(0, 12));
      tx_frame(8'($urandom), $urandom_range(0, 2));
      ctrl_chk("tx_ctrl");
    end

    // Reset mid-frame, then divisor clamp
    set_div(8);
    wb_write(1'b0, 4'b0001, 32'h00);
    repeat (3) begin @(posedge CLK_I); #1; end
    check("tx_low_pre_rst", usartTX, 0);
    RST_I = 1'b1;
    #1;
    check("tx_async_rst", usartTX, 1);
    @(posedge CLK_I); #1;
    RST_I = 1'b0;
    model_reset();
    ctrl_chk("post_rst_ctrl");
    set_div(2);
    tx_frame(8'hC5, 0);

    // RX directed
    set_div(16);
    send_frame(8'h3C, 1'b1, 1'b0);
    check("rx_irq_3c", rxirq, 1);
    rd_data_chk("rx_3c");
    rd_data_chk("rx_3c_empty");
    send_frame(8'h81, 1'b0, 1'b0);
    ctrl_chk("rx_ferr");
    clear_flags(32'h4);
    ctrl_chk("rx_ferr_clr");
    glitch(4);
    ctrl_chk("rx_glitch_ctrl");

    // Overrun, then pop coinciding with push
    for (int i = 0; i <= CAP; i++) send_frame(8'($urandom), 1'b1, 1'b0);
    ctrl_chk("ovr_set");
    for (int i = 0; i < CAP; i++) rd_data_chk("ovr_data");
    clear_flags(32'h8);
    for (int i = 0; i < CAP; i++) send_frame(8'($urandom), 1'b1, 1'b0);
    send_frame(8'($urandom), 1'b1, 1'b1);
    ctrl_chk("pop_push_no_ovr");
    for (int i = 0; i < CAP; i++) rd_data_chk("pop_push_data");

    // RX random traffic
    for (int i = 0; i < 45; i++) begin
      op = $urandom_range(0, 10);
      case (op)
        0, 1, 2, 3: send_frame(8'($urandom), 1'b1, $urandom_range(0, 3) == 0);
        4:          send_frame(8'($urandom), 1'b0, 1'b0);
        5: begin
          d = eff(m_div);
          glitch($urandom_range(1, (d >> 1) - 1));
        end
        6, 7: rd_data_chk("rnd_data");
        8:    ctrl_chk("rnd_ctrl");
        9:    clear_flags(32'($urandom_range(0, 3)) << 2);
        default: set_div($urandom_range(8, 24));
      endcase
    end
    ctrl_chk("final_ctrl");
    while (q.size() > 0) rd_data_chk("final_drain");
    wb_read(1'b0, r);
    check("final_empty", r, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
